clic_dispatch: RTL and testbench
================================

Name: clic_dispatch

Overview:
- Sequential dispatch stage directly downstream of the combinational CLIC arbiter.
- Consumes the arbiter winner (valid, index, priority) and decides whether it preempts the running context.
- Issues a valid/ready interrupt request to the core, then pulses a pending-clear back to the entry table.
- Keeps a nesting stack of preempted priority levels, popped on each core return (mret).

Parameters:
- NUM_ENTRIES, 4, number of interrupt entries; index width IDX_W = $clog2(NUM_ENTRIES).
- PRIO_WIDTH, 2, priority field width; 0 = thread level, never preempts.
- STACK_DEPTH, 4, maximum nesting depth; depth counter width DEP_W = $clog2(STACK_DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- arb_valid  in  1  arbiter is_interrupt.
- arb_index  in  IDX_W  arbiter winning index.
- arb_prio  in  PRIO_WIDTH  priority of the winning entry.
- irq_valid  out  1  request to core.
- irq_ready  in  1  core accepts the request.
- irq_index  out  IDX_W  requested entry index.
- irq_prio  out  PRIO_WIDTH  requested priority.
- mret  in  1  single-cycle pulse: core returns from the current handler.
- clr_valid  out  1  one-cycle pulse: clear pending for clr_index.
- clr_index  out  IDX_W  entry to clear.
- cur_prio  out  PRIO_WIDTH  running priority level.
- depth  out  DEP_W  current nesting depth.
- underflow_err  out  1  sticky; set on mret with depth==0.

Behaviour:
- Reset: synchronous, active-high; applies on any clk edge with reset=1 and overrides every other event, including mid-REQ.
  - All outputs 0; stack contents 0; state IDLE.
  - An in-flight request is dropped and no clear is issued.
- FSM states: IDLE, REQ, SETTLE.
- Qualify condition: arb_valid & (arb_prio > cur_prio) & (depth < STACK_DEPTH). Comparison is strictly greater and unsigned.
- IDLE: if qualified at edge N, then from cycle N+1:
  - state=REQ, irq_valid=1;
  - irq_index/irq_prio latched from arb_index/arb_prio.
- REQ:
  - irq_valid, irq_index and irq_prio are held stable until the handshake, even if arbiter inputs change or drop.
  - A higher-priority arrival does not replace the latched request.
  - Handshake = irq_valid & irq_ready at edge M. Effects visible in cycle M+1:
    - stack[depth] <= cur_prio; depth+1; cur_prio <= irq_prio;
    - clr_valid=1 and clr_index=irq_index for exactly one cycle;
    - irq_valid=0; state=SETTLE.
- SETTLE: one-cycle bubble so the cleared pending bit propagates through the arbiter; no qualification evaluated; next state IDLE.
- Dispatch latency: arbiter winner to irq_valid = 1 cycle. Minimum back-to-back dispatch period = 3 cycles (REQ, SETTLE, IDLE).
- mret, in any state:
  - depth>0: depth-1; cur_prio <= stack[depth-1].
  - depth==0: no state change; underflow_err <= 1, cleared only by reset.
- mret and handshake on the same edge:
  - Pop first, then push. Net depth is unchanged.
  - Pushed value = popped prio; cur_prio = irq_prio.
- mret in REQ without handshake:
  - cur_prio drops; the pending request is kept and still completes.
- Full stack (depth==STACK_DEPTH): no new request is raised; an already-raised REQ can only exist if depth<STACK_DEPTH at raise time, so there is no overflow.
- Priority 0 winner: never qualifies, because cur_prio >= 0.

Test Plan:
- Single dispatch: reset; arb_valid=1, idx=3, prio=1, irq_ready=1 -> irq_valid at cycle 1; clr_valid pulse idx 3 at cycle 2; cur_prio=1, depth=1.
- Preemption/nesting: cur_prio=1 active; arb idx=2 prio=3 -> dispatched, depth=2, cur_prio=3. mret -> cur_prio=1, depth=1. mret -> cur_prio=0, depth=0.
- No preempt: cur_prio=2; arb prio=2, then prio=1 -> irq_valid stays 0 for 10 cycles. Raise to prio=3 -> irq_valid next cycle.
- Backpressure/stability: irq_ready=0 for 5 cycles while arb switches idx 3->1 and prio 1->3 -> irq_index=3, irq_prio=1 held. ready=1 -> clear idx 3.
- Stack full and edges: STACK_DEPTH=4 filled with prios 0->1->2->3 (cur_prio=3 after 3 dispatches; depth=4 needs a 4th level, so use PRIO_WIDTH=3) -> prio 7 not raised at depth 4. Then:
  - mret together with handshake -> depth unchanged.
  - mret at depth 0 -> underflow_err=1.
- Reset mid-REQ: irq_valid=1, ready=0, assert reset one cycle -> all outputs 0 next cycle, no clr_valid pulse.

Source files
------------

// File: rtl/clic_dispatch.sv
// CLIC dispatch stage: turns the arbiter winner into a core request, clears its
// pending bit after the handshake and tracks preempted priority levels on a stack.
module clic_dispatch #(
    parameter  int NUM_ENTRIES = 4,
    parameter  int PRIO_WIDTH  = 2,
    parameter  int STACK_DEPTH = 4,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int DEP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  arb_valid_i,
    input  logic [IDX_W-1:0]      arb_index_i,
    input  logic [PRIO_WIDTH-1:0] arb_prio_i,
    output logic                  irq_valid_o,
    input  logic                  irq_ready_i,
    output logic [IDX_W-1:0]      irq_index_o,
    output logic [PRIO_WIDTH-1:0] irq_prio_o,
    input  logic                  mret_i,
    output logic                  clr_valid_o,
    output logic [IDX_W-1:0]      clr_index_o,
    output logic [PRIO_WIDTH-1:0] cur_prio_o,
    output logic [DEP_W-1:0]      depth_o,
    output logic                  underflow_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]      idx;
        logic [PRIO_WIDTH-1:0] prio;
    } req_t;

    localparam logic [DEP_W-1:0] FULL = DEP_W'(STACK_DEPTH);

    state_t                state_q;
    req_t                  req_q;
    logic                  irq_valid_q;
    logic                  clr_valid_q;
    logic [IDX_W-1:0]      clr_index_q;
    logic [PRIO_WIDTH-1:0] cur_prio_q, cur_prio_d;
    logic [DEP_W-1:0]      depth_q, depth_d;
    logic                  underflow_q;
    logic [PRIO_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                  qualify;
    logic                  hs;
    logic                  pop_ok;
    logic [PRIO_WIDTH-1:0] stack_top;
    logic [DEP_W-1:0]      dep_pop;
    logic [PRIO_WIDTH-1:0] prio_pop;

    assign qualify = arb_valid_i && (arb_prio_i > cur_prio_q) && (depth_q < FULL);
    assign hs      = (state_q == REQ) && irq_valid_q && irq_ready_i;
    assign pop_ok  = mret_i && (depth_q != '0);

    // A same-edge mret pops before the handshake pushes, so the push lands on
    // the popped slot with the popped level and depth nets out unchanged.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEP_W'(i + 1)) stack_top = stack_q[i];
        end
        dep_pop    = pop_ok ? depth_q - 1'b1 : depth_q;
        prio_pop   = pop_ok ? stack_top : cur_prio_q;
        depth_d    = hs ? dep_pop + 1'b1 : dep_pop;
        cur_prio_d = hs ? req_q.prio : prio_pop;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (hs) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (dep_pop == DEP_W'(i)) stack_q[i] <= prio_pop;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            irq_valid_q <= 1'b0;
            clr_valid_q <= 1'b0;
            clr_index_q <= '0;
            cur_prio_q  <= '0;
            depth_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            clr_valid_q <= hs;
            cur_prio_q  <= cur_prio_d;
            depth_q     <= depth_d;
            if (mret_i && !pop_ok) underflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (qualify) begin
                        state_q     <= REQ;
                        irq_valid_q <= 1'b1;
                        req_q       <= '{idx: arb_index_i, prio: arb_prio_i};
                    end
                end
                REQ: begin
                    // Request stays latched until accepted; later winners wait.
                    if (hs) begin
                        state_q     <= SETTLE;
                        irq_valid_q <= 1'b0;
                        clr_index_q <= req_q.idx;
                    end
                end
                SETTLE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_valid_o     = irq_valid_q;
    assign irq_index_o     = req_q.idx;
    assign irq_prio_o      = req_q.prio;
    assign clr_valid_o     = clr_valid_q;
    assign clr_index_o     = clr_index_q;
    assign cur_prio_o      = cur_prio_q;
    assign depth_o         = depth_q;
    assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_clic_dispatch.sv
// Bench for clic_dispatch: cycle-by-cycle vector table plus directed sequences
// for hold-off and backpressure.
module tb_clic_dispatch;

    localparam int NE = 4;
    localparam int PW = 3;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arb_valid = 1'b0;
    logic [1:0] arb_index = '0;
    logic [2:0] arb_prio = '0;
    logic       irq_ready = 1'b0;
    logic       mret = 1'b0;
    logic       irq_valid, clr_valid, underflow_err;
    logic [1:0] irq_index, clr_index;
    logic [2:0] irq_prio, cur_prio, depth;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clic_dispatch #(.NUM_ENTRIES(NE), .PRIO_WIDTH(PW), .STACK_DEPTH(SD)) dut (
        .clk_i(clk), .reset_i(reset),
        .arb_valid_i(arb_valid), .arb_index_i(arb_index), .arb_prio_i(arb_prio),
        .irq_valid_o(irq_valid), .irq_ready_i(irq_ready),
        .irq_index_o(irq_index), .irq_prio_o(irq_prio),
        .mret_i(mret), .clr_valid_o(clr_valid), .clr_index_o(clr_index),
        .cur_prio_o(cur_prio), .depth_o(depth), .underflow_err_o(underflow_err)
    );

    typedef struct {
        logic       rst, av;
        logic [1:0] ai;
        logic [2:0] ap;
        logic       rdy, mr;
        logic       iv;
        logic [1:0] ii;
        logic [2:0] ip;
        logic       cv;
        logic [1:0] ci;
        logic [2:0] cp, d;
        logic       uf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int rst, av, ai, ap, rdy, mr,
                                input int iv, ii, ip, cv, ci, cp, d, uf);
        vec_t v;
        v.rst = rst[0]; v.av = av[0]; v.ai = ai[1:0]; v.ap = ap[2:0];
        v.rdy = rdy[0]; v.mr = mr[0];
        v.iv = iv[0]; v.ii = ii[1:0]; v.ip = ip[2:0]; v.cv = cv[0];
        v.ci = ci[1:0]; v.cp = cp[2:0]; v.d = d[2:0]; v.uf = uf[0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; arb_valid = 1'b0; irq_ready = 1'b0; mret = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        //              rst av ai ap rdy mr | iv ii ip cv ci cp d uf
        vt.push_back(mk(1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0)); // reset
        vt.push_back(mk(0, 1, 3, 1, 1, 0,    1, 3, 1, 0, 0, 0, 0, 0)); // single dispatch
        vt.push_back(mk(0, 1, 3, 1, 1, 0,    0, 3, 1, 1, 3, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0,    0, 3, 1, 0, 3, 1, 1, 0));
        vt.push_back(mk(0, 1, 2, 3, 1, 0,    1, 2, 3, 0, 3, 1, 1, 0)); // preempt
        vt.push_back(mk(0, 1, 2, 3, 1, 0,    0, 2, 3, 1, 2, 3, 2, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0,    0, 2, 3, 0, 2, 3, 2, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1,    0, 2, 3, 0, 2, 1, 1, 0)); // mret
        vt.push_back(mk(0, 0, 0, 0, 1, 1,    0, 2, 3, 0, 2, 0, 0, 0)); // mret
        vt.push_back(mk(0, 0, 0, 0, 1, 0,    0, 2, 3, 0, 2, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 2, 0, 0,    1, 1, 2, 0, 2, 0, 0, 0)); // reset mid-REQ
        vt.push_back(mk(1, 1, 1, 2, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 1, 0,    1, 0, 1, 0, 0, 0, 0, 0)); // fill stack
        vt.push_back(mk(0, 1, 0, 1, 1, 0,    0, 0, 1, 1, 0, 1, 1, 0));
        vt.push_back(mk(0, 1, 1, 2, 1, 0,    0, 0, 1, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 1, 1, 2, 1, 0,    1, 1, 2, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 1, 1, 2, 1, 0,    0, 1, 2, 1, 1, 2, 2, 0));
        vt.push_back(mk(0, 1, 2, 3, 1, 0,    0, 1, 2, 0, 1, 2, 2, 0));
        vt.push_back(mk(0, 1, 2, 3, 1, 0,    1, 2, 3, 0, 1, 2, 2, 0));
        vt.push_back(mk(0, 1, 2, 3, 1, 0,    0, 2, 3, 1, 2, 3, 3, 0));
        vt.push_back(mk(0, 1, 3, 4, 1, 0,    0, 2, 3, 0, 2, 3, 3, 0));
        vt.push_back(mk(0, 1, 3, 4, 1, 0,    1, 3, 4, 0, 2, 3, 3, 0));
        vt.push_back(mk(0, 1, 3, 4, 1, 0,    0, 3, 4, 1, 3, 4, 4, 0));
        vt.push_back(mk(0, 1, 1, 7, 1, 0,    0, 3, 4, 0, 3, 4, 4, 0));
        vt.push_back(mk(0, 1, 1, 7, 1, 0,    0, 3, 4, 0, 3, 4, 4, 0)); // full: no raise
        vt.push_back(mk(0, 1, 1, 7, 1, 0,    0, 3, 4, 0, 3, 4, 4, 0));
        vt.push_back(mk(0, 1, 1, 7, 1, 1,    0, 3, 4, 0, 3, 3, 3, 0)); // pop to 3
        vt.push_back(mk(0, 1, 1, 7, 1, 0,    1, 1, 7, 0, 3, 3, 3, 0)); // raise prio 7
        vt.push_back(mk(0, 1, 1, 7, 0, 1,    1, 1, 7, 0, 3, 2, 2, 0)); // mret in REQ
        vt.push_back(mk(0, 1, 1, 7, 1, 1,    0, 1, 7, 1, 1, 7, 2, 0)); // mret + handshake
        vt.push_back(mk(0, 0, 0, 0, 1, 1,    0, 1, 7, 0, 1, 1, 1, 0)); // pushed level = 1
        vt.push_back(mk(0, 0, 0, 0, 1, 1,    0, 1, 7, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1,    0, 1, 7, 0, 1, 0, 0, 1)); // underflow
        vt.push_back(mk(0, 0, 0, 0, 1, 0,    0, 1, 7, 0, 1, 0, 0, 1)); // sticky
        vt.push_back(mk(1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0)); // prio 0 never
        vt.push_back(mk(0, 1, 2, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0));

        #1;
        foreach (vt[i]) begin
            reset = vt[i].rst; arb_valid = vt[i].av; arb_index = vt[i].ai;
            arb_prio = vt[i].ap; irq_ready = vt[i].rdy; mret = vt[i].mr;
            tick();
            chk($sformatf("v%0d irq_valid", i), int'(irq_valid), int'(vt[i].iv));
            chk($sformatf("v%0d irq_index", i), int'(irq_index), int'(vt[i].ii));
            chk($sformatf("v%0d irq_prio", i), int'(irq_prio), int'(vt[i].ip));
            chk($sformatf("v%0d clr_valid", i), int'(clr_valid), int'(vt[i].cv));
            chk($sformatf("v%0d clr_index", i), int'(clr_index), int'(vt[i].ci));
            chk($sformatf("v%0d cur_prio", i), int'(cur_prio), int'(vt[i].cp));
            chk($sformatf("v%0d depth", i), int'(depth), int'(vt[i].d));
            chk($sformatf("v%0d underflow", i), int'(underflow_err), int'(vt[i].uf));
        end

        // Equal and lower priority never preempt the running level.
        do_reset();
        arb_valid = 1'b1; arb_index = 2'd0; arb_prio = 3'd2; irq_ready = 1'b1;
        tick(); tick();
        arb_valid = 1'b0;
        tick();
        chk("np cur_prio", int'(cur_prio), 2);
        arb_valid = 1'b1; arb_prio = 3'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("np equal irq_valid", int'(irq_valid), 0);
        end
        arb_prio = 3'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("np lower irq_valid", int'(irq_valid), 0);
        end
        arb_prio = 3'd3; arb_index = 2'd1;
        tick();
        chk("np raise irq_valid", int'(irq_valid), 1);
        chk("np raise irq_index", int'(irq_index), 1);

        // Backpressure: latched request survives arbiter changes.
        do_reset();
        arb_valid = 1'b1; arb_index = 2'd3; arb_prio = 3'd1;
        tick();
        chk("bp irq_valid", int'(irq_valid), 1);
        arb_index = 2'd1; arb_prio = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold irq_valid", int'(irq_valid), 1);
            chk("bp hold irq_index", int'(irq_index), 3);
            chk("bp hold irq_prio", int'(irq_prio), 1);
            chk("bp hold clr_valid", int'(clr_valid), 0);
        end
        irq_ready = 1'b1;
        tick();
        chk("bp clr_valid", int'(clr_valid), 1);
        chk("bp clr_index", int'(clr_index), 3);
        chk("bp cur_prio", int'(cur_prio), 1);
        chk("bp depth", int'(depth), 1);
        chk("bp irq_valid drop", int'(irq_valid), 0);
        arb_valid = 1'b0;
        tick();
        chk("bp clr pulse width", int'(clr_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
